bip_control: RTL and testbench

- Sequencing/control unit of the accumulator-based processor; sits directly upstream of the accumulator register.
- Fetches 16-bit instructions from program memory, decodes them, and drives the datapath: operand mux selects, ALU op, and the single-cycle accumulator write/clear strobes.
- Also drives data-memory read/write strobes, the program counter, halt status and a cycle counter.

---
 rtl/bip_control.sv | 273 +++++++++++++++++++++++++++
 tb/tb_bip_control.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// ---------------------------------------------------------------------------
// bip_control
//
// Sequencer/decoder for the accumulator-based processor. It walks a
// FETCH/EXEC(/MEMWAIT) loop over program memory and drives the accumulator
// datapath and the data-memory strobes that sit downstream of it.
//
// Every output comes straight from a flop. Each *_d value is therefore
// computed one cycle ahead of the state it belongs to. For example, the
// EXEC-cycle strobes are decoded from instr_i during FETCH, so they are
// already high for the whole EXEC cycle.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      level; only sampled in IDLE
//   instr_i      program memory data, sampled at the end of FETCH
//   pc_addr_o    program memory address
//   operand_o    instr[10:0] of the current instruction; data memory address
//   imm_o        operand sign-extended to DB bits
//   sel_a_o      accumulator input mux: 0=ram data, 1=imm, 2=ALU result
//   sel_b_o      ALU B mux: 0=ram data, 1=imm
//   alu_op_o     0=add, 1=sub
//   wr_acc_o     accumulator load strobe (1 clk)
//   clear_acc_o  accumulator clear strobe (1 clk, first FETCH after IDLE)
//   rd_ram_o     data memory read strobe
//   wr_ram_o     data memory write strobe (stores acc)
//   halted_o     high while in HALT
//   cyc_count_o  saturating count of clocks spent in FETCH/EXEC/MEMWAIT
// ---------------------------------------------------------------------------
module bip_control #(
    parameter int unsigned PC_W  = 11,
    parameter int unsigned DB    = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [15:0]      instr_i,
    output logic [PC_W-1:0]  pc_addr_o,
    output logic [PC_W-1:0]  operand_o,
    output logic [DB-1:0]    imm_o,
    output logic [1:0]       sel_a_o,
    output logic             sel_b_o,
    output logic             alu_op_o,
    output logic             wr_acc_o,
    output logic             clear_acc_o,
    output logic             rd_ram_o,
    output logic             wr_ram_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cyc_count_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMemWait,
        StHalt
    } state_e;

    localparam logic [4:0] OpHlt  = 5'b00000;
    localparam logic [4:0] OpSto  = 5'b00001;
    localparam logic [4:0] OpLd   = 5'b00010;
    localparam logic [4:0] OpLdi  = 5'b00011;
    localparam logic [4:0] OpAdd  = 5'b00100;
    localparam logic [4:0] OpAddi = 5'b00101;
    localparam logic [4:0] OpSub  = 5'b00110;
    localparam logic [4:0] OpSubi = 5'b00111;

    localparam logic [1:0] SelRam = 2'd0;
    localparam logic [1:0] SelImm = 2'd1;
    localparam logic [1:0] SelAlu = 2'd2;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [4:0]       op_q, op_d;
    logic [PC_W-1:0]  operand_q, operand_d;
    logic [1:0]       sel_a_q, sel_a_d;
    logic             sel_b_q, sel_b_d;
    logic             alu_op_q, alu_op_d;
    logic             wr_acc_q, wr_acc_d;
    logic             clear_acc_q, clear_acc_d;
    logic             rd_ram_q, rd_ram_d;
    logic             wr_ram_q, wr_ram_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic             op_is_mem;
    logic             fetch_is_mem;
    logic             active;

    // Memory-operand instructions take the extra MEMWAIT cycle.
    assign op_is_mem    = (op_q == OpLd) || (op_q == OpAdd) || (op_q == OpSub);
    assign fetch_is_mem = (instr_i[15:11] == OpLd) || (instr_i[15:11] == OpAdd) ||
                          (instr_i[15:11] == OpSub);
    assign active       = (state_q == StFetch) || (state_q == StExec) ||
                          (state_q == StMemWait);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StExec;
            end
            StExec: begin
                if (op_q == OpHlt) begin
                    state_d = StHalt;
                end else if (op_is_mem) begin
                    state_d = StMemWait;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemWait: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // Strobes default low; mux selects and alu_op hold their last value.
        pc_d        = pc_q;
        op_d        = op_q;
        operand_d   = operand_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        alu_op_d    = alu_op_q;
        wr_acc_d    = 1'b0;
        clear_acc_d = 1'b0;
        rd_ram_d    = 1'b0;
        wr_ram_d    = 1'b0;
        halted_d    = (state_d == StHalt);

        unique case (state_q)
            StIdle: begin
                clear_acc_d = start_i;
            end
            StFetch: begin
                // Latch the instruction and set up the EXEC-cycle outputs.
                op_d      = instr_i[15:11];
                operand_d = instr_i[PC_W-1:0];
                unique case (instr_i[15:11])
                    OpLdi: begin
                        wr_acc_d = 1'b1;
                        sel_a_d  = SelImm;
                        sel_b_d  = 1'b1;
                        alu_op_d = 1'b0;
                    end
                    OpAddi: begin
                        wr_acc_d = 1'b1;
                        sel_a_d  = SelAlu;
                        sel_b_d  = 1'b1;
                        alu_op_d = 1'b0;
                    end
                    OpSubi: begin
                        wr_acc_d = 1'b1;
                        sel_a_d  = SelAlu;
                        sel_b_d  = 1'b1;
                        alu_op_d = 1'b1;
                    end
                    OpSto: begin
                        wr_ram_d = 1'b1;
                    end
                    default: begin
                        rd_ram_d = fetch_is_mem;
                    end
                endcase
            end
            StExec: begin
                if (op_is_mem) begin
                    // Set up the MEMWAIT-cycle accumulator load from ram data.
                    wr_acc_d = 1'b1;
                    sel_a_d  = (op_q == OpLd) ? SelRam : SelAlu;
                    sel_b_d  = 1'b0;
                    if (op_q != OpLd) begin
                        alu_op_d = (op_q == OpSub);
                    end
                end else if (op_q != OpHlt) begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            StMemWait: begin
                pc_d = pc_q + PC_W'(1);
            end
            default: begin
            end
        endcase
    end

    // Saturating cycle counter, frozen outside the active states.
    always_comb begin
        cyc_d = cyc_q;
        if (active && (cyc_q != {CNT_W{1'b1}})) begin
            cyc_d = cyc_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Output / datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= '0;
            op_q        <= OpHlt;
            operand_q   <= '0;
            sel_a_q     <= SelRam;
            sel_b_q     <= 1'b0;
            alu_op_q    <= 1'b0;
            wr_acc_q    <= 1'b0;
            clear_acc_q <= 1'b0;
            rd_ram_q    <= 1'b0;
            wr_ram_q    <= 1'b0;
            halted_q    <= 1'b0;
            cyc_q       <= '0;
        end else begin
            pc_q        <= pc_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            alu_op_q    <= alu_op_d;
            wr_acc_q    <= wr_acc_d;
            clear_acc_q <= clear_acc_d;
            rd_ram_q    <= rd_ram_d;
            wr_ram_q    <= wr_ram_d;
            halted_q    <= halted_d;
            cyc_q       <= cyc_d;
        end
    end

    assign pc_addr_o   = pc_q;
    assign operand_o   = operand_q;
    assign imm_o       = {{(DB - PC_W){operand_q[PC_W-1]}}, operand_q};
    assign sel_a_o     = sel_a_q;
    assign sel_b_o     = sel_b_q;
    assign alu_op_o    = alu_op_q;
    assign wr_acc_o    = wr_acc_q;
    assign clear_acc_o = clear_acc_q;
    assign rd_ram_o    = rd_ram_q;
    assign wr_ram_o    = wr_ram_q;
    assign halted_o    = halted_q;
    assign cyc_count_o = cyc_q;

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic [10:0] pc_addr;
    logic [10:0] operand;
    logic [15:0] imm;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        alu_op;
    logic        wr_acc;
    logic        clear_acc;
    logic        rd_ram;
    logic        wr_ram;
    logic        halted;
    logic [15:0] cyc_count;

    int n_checks = 0;
    int n_fail   = 0;

    bip_control #(
        .PC_W  (11),
        .DB    (16),
        .CNT_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .instr_i     (instr),
        .pc_addr_o   (pc_addr),
        .operand_o   (operand),
        .imm_o       (imm),
        .sel_a_o     (sel_a),
        .sel_b_o     (sel_b),
        .alu_op_o    (alu_op),
        .wr_acc_o    (wr_acc),
        .clear_acc_o (clear_acc),
        .rd_ram_o    (rd_ram),
        .wr_ram_o    (wr_ram),
        .halted_o    (halted),
        .cyc_count_o (cyc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: address captured mid-cycle, data ready for the next rising edge.
    logic [15:0] mem [0:2047];
    always @(negedge clk) instr <= mem[pc_addr];

    // Strobe-cycle record: {clr, wr_acc, rd_ram, wr_ram, sel_a, sel_b, alu_op,
    // operand, imm, pc, cyc}
    typedef struct packed {
        logic        clr;
        logic        wra;
        logic        rdr;
        logic        wrr;
        logic [1:0]  sa;
        logic        sb;
        logic        alu;
        logic [10:0] opd;
        logic [15:0] imm;
        logic [10:0] pc;
        logic [15:0] cyc;
    } ev_t;

    ev_t exp_q[$];

    task automatic push(input logic [3:0] strb, input logic [1:0] sa, input logic sb,
                        input logic alu, input logic [10:0] opd, input logic [15:0] im,
                        input logic [10:0] pc, input logic [15:0] cyc);
        ev_t e;
        e = '{clr: strb[3], wra: strb[2], rdr: strb[1], wrr: strb[0], sa: sa, sb: sb,
              alu: alu, opd: opd, imm: im, pc: pc, cyc: cyc};
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with a strobe high is matched against the scoreboard.
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        if (rst_n && (wr_acc || clear_acc || rd_ram || wr_ram)) begin
            a = '{clr: clear_acc, wra: wr_acc, rdr: rd_ram, wrr: wr_ram, sa: sel_a,
                  sb: sel_b, alu: alu_op, opd: operand, imm: imm, pc: pc_addr,
                  cyc: cyc_count};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe got=%h expected=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL strobe_event got=%h expected=%h", a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_mem(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) mem[i] = w;
    endtask

    task automatic wait_halt(input string name, input int lim);
        int n;
        n = 0;
        while (!halted && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic wait_pc(input string name, input logic [10:0] target, input int lim);
        int n;
        n = 0;
        while (pc_addr !== target && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pc_reached"}, 32'(pc_addr), 32'(target));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill_mem(16'h0000);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_pc", 32'(pc_addr), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_strobes", {28'd0, wr_acc, clear_acc, rd_ram, wr_ram}, 32'd0);
        chk("rst_sel", {28'd0, sel_a, sel_b, alu_op}, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cyc", 32'(cyc_count), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_pc", 32'(pc_addr), 32'd0);
        chk("idle_cyc", 32'(cyc_count), 32'd0);

        // LDI 5 ; HLT
        mem[0] = 16'h1805;
        mem[1] = 16'h0000;
        push(4'b1000, 2'd0, 1'b0, 1'b0, 11'h000, 16'h0000, 11'd0, 16'd0);
        push(4'b0100, 2'd1, 1'b1, 1'b0, 11'h005, 16'h0005, 11'd0, 16'd1);
        start = 1'b1;
        wait_halt("p1", 20);
        chk("p1_pc", 32'(pc_addr), 32'd1);
        chk("p1_cyc", 32'(cyc_count), 32'd4);
        chk("p1_queue_empty", 32'(exp_q.size()), 32'd0);

        // HALT ignores start
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
        end
        repeat (2) @(negedge clk);
        chk("halt_still_halted", 32'(halted), 32'd1);
        chk("halt_cyc_frozen", 32'(cyc_count), 32'd4);
        chk("halt_pc_frozen", 32'(pc_addr), 32'd1);

        // LDI 0x7FF ; ADDI 0x401 ; HLT
        do_reset();
        fill_mem(16'h0000);
        mem[0] = 16'h1FFF;
        mem[1] = 16'h2C01;
        push(4'b1000, 2'd0, 1'b0, 1'b0, 11'h000, 16'h0000, 11'd0, 16'd0);
        push(4'b0100, 2'd1, 1'b1, 1'b0, 11'h7FF, 16'hFFFF, 11'd0, 16'd1);
        push(4'b0100, 2'd2, 1'b1, 1'b0, 11'h401, 16'hFC01, 11'd1, 16'd3);
        start = 1'b1;
        wait_halt("p2", 20);
        chk("p2_pc", 32'(pc_addr), 32'd2);
        chk("p2_cyc", 32'(cyc_count), 32'd6);
        chk("p2_queue_empty", 32'(exp_q.size()), 32'd0);

        // LD 3 ; SUB 4 ; STO 5 ; HLT
        do_reset();
        fill_mem(16'h0000);
        mem[0] = 16'h1003;
        mem[1] = 16'h3004;
        mem[2] = 16'h0805;
        push(4'b1000, 2'd0, 1'b0, 1'b0, 11'h000, 16'h0000, 11'd0, 16'd0);
        push(4'b0010, 2'd0, 1'b0, 1'b0, 11'h003, 16'h0003, 11'd0, 16'd1);
        push(4'b0100, 2'd0, 1'b0, 1'b0, 11'h003, 16'h0003, 11'd0, 16'd2);
        push(4'b0010, 2'd0, 1'b0, 1'b0, 11'h004, 16'h0004, 11'd1, 16'd4);
        push(4'b0100, 2'd2, 1'b0, 1'b1, 11'h004, 16'h0004, 11'd1, 16'd5);
        push(4'b0001, 2'd2, 1'b0, 1'b1, 11'h005, 16'h0005, 11'd2, 16'd7);
        start = 1'b1;
        wait_halt("p3", 30);
        chk("p3_pc", 32'(pc_addr), 32'd3);
        chk("p3_cyc", 32'(cyc_count), 32'd10);
        chk("p3_queue_empty", 32'(exp_q.size()), 32'd0);

        // ADD 7, reset asserted just after entering MEMWAIT
        do_reset();
        fill_mem(16'h0000);
        mem[0] = 16'h2007;
        push(4'b1000, 2'd0, 1'b0, 1'b0, 11'h000, 16'h0000, 11'd0, 16'd0);
        push(4'b0010, 2'd0, 1'b0, 1'b0, 11'h007, 16'h0007, 11'd0, 16'd1);
        start = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rd_ram && n < 10);
            chk("p5_rd_ram_seen", 32'(rd_ram), 32'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("p5_wr_acc_cancelled", 32'(wr_acc), 32'd0);
        chk("p5_pc", 32'(pc_addr), 32'd0);
        chk("p5_cyc", 32'(cyc_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("p5_idle_pc", 32'(pc_addr), 32'd0);
        chk("p5_idle_cyc", 32'(cyc_count), 32'd0);
        chk("p5_idle_halted", 32'(halted), 32'd0);
        chk("p5_queue_empty", 32'(exp_q.size()), 32'd0);

        // All-NOP program: pc walks the whole space and wraps
        do_reset();
        fill_mem(16'h4000);
        push(4'b1000, 2'd0, 1'b0, 1'b0, 11'h000, 16'h0000, 11'd0, 16'd0);
        start = 1'b1;
        wait_pc("nop_top", 11'd2047, 5000);
        chk("nop_cyc_at_top", 32'(cyc_count), 32'd4094);
        wait_pc("nop_wrap", 11'd0, 10);
        chk("nop_cyc_at_wrap", 32'(cyc_count), 32'd4096);
        chk("nop_queue_empty", 32'(exp_q.size()), 32'd0);
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
